// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM state encoding and
// the expected-output tables of the common 2-input gates.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit i is the gate output expected when the input vector equals i.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/settle_timer.sv
// Loadable up/down counter with clear, enable and a terminal-count flag.
// The flag compares the current count against tc_val.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (en)   cnt_d = up ? cnt_q + W'(1) : cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val);

endmodule

// File: rtl/truth_table_scanner.sv
// Drives a combinational gate through every input vector, waits SETTLE cycles
// per vector, captures the gate output and compares it with EXPECTED.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int                   N_IN     = 2,
  parameter int                   SETTLE   = 1,
  parameter logic [2**N_IN-1:0]   EXPECTED = 4'b1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [N_IN-1:0]     vec,
  input  logic                s_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  table_out,
  output logic [N_IN:0]       err_count
);

  localparam int                NV       = 2**N_IN;
  localparam int                CW       = $clog2(SETTLE) + 1;
  localparam logic [N_IN-1:0]   VEC_LAST = N_IN'(NV - 1);
  localparam logic [CW-1:0]     TC_VAL   = CW'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [NV-1:0]     tbl_q, tbl_d;
  logic [N_IN:0]     err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              tmr_clr, tmr_en, tmr_tc;
  logic              mis;

  settle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .clr      (tmr_clr),
    .load     (1'b0),
    .en       (tmr_en),
    .up       (1'b1),
    .load_val ('0),
    .tc_val   (TC_VAL),
    .tc_o     (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    mis     = (s_in != EXPECTED[vec_q]);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          vec_d   = '0;
          tbl_d   = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmr_clr = 1'b1;
        end
      end
      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        tbl_d[vec_q] = s_in;
        err_d        = err_q + (N_IN+1)'(mis);
        if (vec_q == VEC_LAST) begin
          // pass must see the compare of the final vector, hence err_d
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + N_IN'(1);
          tmr_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      tbl_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign table_out = tbl_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: random gate tables scanned by the default scanner,
// plus a SETTLE=3 XOR scanner, compared against a table-level reference.
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start3;
  logic [3:0] gate_tt;
  logic       glitch;

  logic [1:0] vec, vec3;
  logic       s_in, s_in3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [3:0] table_out, table3;
  logic [2:0] err_count, err3;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // gate under test: arbitrary truth table, optional glitch injected on the output
  assign s_in  = gate_tt[vec] ^ glitch;
  assign s_in3 = vec3[0] ^ vec3[1];

  truth_table_scanner #(.N_IN(2), .SETTLE(1), .EXPECTED(TT_AND)) u_dut (
    .clk(clk), .reset(rst), .start(start), .vec(vec), .s_in(s_in),
    .busy(busy), .done(done), .pass(pass), .table_out(table_out), .err_count(err_count)
  );

  truth_table_scanner #(.N_IN(2), .SETTLE(3), .EXPECTED(TT_XOR)) u_dut3 (
    .clk(clk), .reset(rst), .start(start3), .vec(vec3), .s_in(s_in3),
    .busy(busy3), .done(done3), .pass(pass3), .table_out(table3), .err_count(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_errors(input logic [3:0] got, input logic [3:0] want);
    int n = 0;
    for (int i = 0; i < 4; i++) if (got[i] != want[i]) n++;
    return n;
  endfunction

  // Full scan: results equal the gate's own table, cost 4 vectors x 2 cycles.
  task automatic run_scan(input logic [3:0] tt, input bit dbl_start);
    int cyc;
    int exp_err;
    gate_tt = tt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_table", table_out, 0);
    check("start_err", err_count, 0);
    check("start_pass", pass, 0);
    check("start_vec", vec, 0);
    cyc = 0;
    for (int j = 1; j <= 40; j++) begin
      glitch = (j % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (dbl_start && j == 4) start = 1'b1;
      tick();
      start  = 1'b0;
      glitch = 1'b0;
      if (done === 1'b1) begin
        cyc = j;
        break;
      end
    end
    exp_err = ref_errors(tt, TT_AND);
    check("done_cycles", cyc, 8);
    check("end_busy", busy, 0);
    check("end_table", table_out, tt);
    check("end_err", err_count, exp_err);
    check("end_pass", pass, (exp_err == 0));
    check("end_vec", vec, 3);
  endtask

  initial begin
    int cyc3;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; gate_tt = TT_AND; glitch = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_vec", vec, 0);
    check("rst_table", table_out, 0);
    check("rst_err", err_count, 0);
    #12 rst = 1'b0;
    tick();
    tick();

    run_scan(TT_AND, 0);
    run_scan(TT_OR, 0);
    run_scan(TT_AND, 1);
    run_scan(TT_NOR, 0);
    for (int r = 0; r < 12; r++)
      run_scan(4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));

    // asynchronous reset mid-scan
    gate_tt = TT_OR;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_vec", vec, 0);
    check("mid_rst_table", table_out, 0);
    check("mid_rst_err", err_count, 0);
    #3 rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);
    run_scan(TT_AND, 0);

    // reset held together with start stays idle
    rst = 1'b1; start = 1'b1;
    tick();
    check("rst_start_busy", busy, 0);
    check("rst_start_done", done, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_idle", busy, 0);

    // SETTLE=3 XOR scanner: vec advances every 4 cycles, done after 16
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc3 = 0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      check("s3_vec", vec3, (j / 4 > 3) ? 3 : j / 4);
      if (done3 === 1'b1) begin
        cyc3 = j;
        break;
      end
    end
    check("s3_done_cycles", cyc3, 16);
    check("s3_busy", busy3, 0);
    check("s3_table", table3, TT_XOR);
    check("s3_err", err3, 0);
    check("s3_pass", pass3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
